// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared types and digit index constants for the score/timer keeper
package score_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_WON     = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_e;

    typedef logic [3:0] bcd_digit_t;

    // Digit 0 is the least significant; the packed layout makes a plain
    // vector compare equal to a decimal compare.
    typedef bcd_digit_t [2:0] bcd3_t;

    localparam int GOAL_BASE  = 0;
    localparam int SCORE_BASE = 3;
    localparam int TIMER_BASE = 6;

endpackage

// File: rtl/bcd3_addsub.sv
// rtl/bcd3_addsub.sv - combinational 3-digit BCD add/subtract of one digit with saturation
//
// Ports:
//   a   - 3-digit BCD operand
//   b   - BCD digit added to / subtracted from a (values above 9 count as 9)
//   sub - 0 = add (saturates at 999), 1 = subtract (floors at 000)
//   y   - result
module bcd3_addsub
    import score_pkg::*;
(
    input  bcd3_t      a,
    input  bcd_digit_t b,
    input  logic       sub,
    output bcd3_t      y
);

    bcd_digit_t b_clamped;
    bcd_digit_t opnd;
    logic [4:0] acc;
    logic       carry;
    bcd3_t      res;

    always_comb begin
        b_clamped = (b > 4'd9) ? 4'd9 : b;
        opnd      = '0;
        acc       = '0;
        carry     = 1'b0;
        res       = '0;
        for (int i = 0; i < 3; i++) begin
            opnd = (i == 0) ? b_clamped : 4'd0;
            if (!sub) begin
                acc = {1'b0, a[i]} + {1'b0, opnd} + {4'b0, carry};
                if (acc > 5'd9) begin
                    acc   = acc - 5'd10;
                    carry = 1'b1;
                end else begin
                    carry = 1'b0;
                end
                res[i] = acc[3:0];
            end else begin
                // acc holds what must be taken from this digit (operand + borrow)
                acc = {1'b0, opnd} + {4'b0, carry};
                if ({1'b0, a[i]} < acc) begin
                    res[i] = 4'(({1'b0, a[i]} + 5'd10) - acc);
                    carry  = 1'b1;
                end else begin
                    res[i] = 4'({1'b0, a[i]} - acc);
                    carry  = 1'b0;
                end
            end
        end
        // Carry out of the top digit means overflow (add) or underflow (subtract)
        if (carry) begin
            y = sub ? 12'h000 : 12'h999;
        end else begin
            y = res;
        end
    end

endmodule

// File: rtl/score_timer_keeper.sv
// rtl/score_timer_keeper.sv - game score, countdown timer and win/timeout state keeper
//
// Optional feature macro: SCORE_PENALTY_EN (enables penalty subtraction).
//
// Ports:
//   clk, resetN          - clock, asynchronous active-low reset
//   startOfFrame         - one pulse per video frame; drives timer and sign fade-out
//   start                - start / restart a game
//   pause                - level, holds the timer
//   addPoints, addValue  - score add request and BCD amount
//   penalty, penaltyValue- score subtract request and BCD amount
//   numbersToShow        - 9 BCD digits: goal [2:0], score [5:3], timer [8:6]
//   SignToShow, ShowSign - last score change direction (1 = minus) and visibility
//   WIN, timeUp          - game won / game lost on time
module score_timer_keeper
    import score_pkg::*;
#(
    parameter int    FRAMES_PER_SEC = 60,
    parameter bcd3_t START_TIME     = 12'h120,
    parameter bcd3_t GOAL           = 12'h100,
    parameter int    SIGN_FRAMES    = 30
) (
    input  logic            clk,
    input  logic            resetN,
    input  logic            startOfFrame,
    input  logic            start,
    input  logic            pause,
    input  logic            addPoints,
    input  logic [3:0]      addValue,
    input  logic            penalty,
    input  logic [3:0]      penaltyValue,
    output logic [8:0][3:0] numbersToShow,
    output logic            SignToShow,
    output logic            ShowSign,
    output logic            WIN,
    output logic            timeUp
);

    localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam int SW = $clog2(SIGN_FRAMES + 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_SEC - 1);

    state_e        state_q;
    bcd3_t         score_q;
    bcd3_t         timer_q;
    logic [FW-1:0] frame_q;
    logic [SW-1:0] sign_cnt_q;
    logic          sign_q;
    logic          show_q;
    logic          win_q;
    logic          time_up_q;

    bcd3_t         score_d;
    bcd3_t         timer_dec;
    logic          score_sub;
    bcd_digit_t    score_val;
    logic          score_req;
    logic          score_ev;
    logic          win_now;

`ifdef SCORE_PENALTY_EN
    // addPoints wins a same-cycle collision, so the penalty is simply not selected
    assign score_sub = ~addPoints;
    assign score_val = addPoints ? addValue : penaltyValue;
    assign score_req = addPoints | penalty;
`else
    logic unused_penalty;
    assign unused_penalty = ^{penalty, penaltyValue};
    assign score_sub = 1'b0;
    assign score_val = addValue;
    assign score_req = addPoints;
`endif

    bcd3_addsub u_score_addsub (
        .a   (score_q),
        .b   (score_val),
        .sub (score_sub),
        .y   (score_d)
    );

    bcd3_addsub u_timer_dec (
        .a   (timer_q),
        .b   (4'd1),
        .sub (1'b1),
        .y   (timer_dec)
    );

    // Score reached goal on a previous edge; this cycle belongs to the win transition
    assign win_now  = (score_q >= GOAL);
    assign score_ev = (state_q == ST_RUN) && !start && !win_now && score_req;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= ST_IDLE;
            score_q    <= '0;
            timer_q    <= START_TIME;
            frame_q    <= '0;
            sign_cnt_q <= '0;
            sign_q     <= 1'b0;
            show_q     <= 1'b0;
            win_q      <= 1'b0;
            time_up_q  <= 1'b0;
        end else begin
            // Sign display runs in every state so it can fade out after a win/timeout
            if (score_ev) begin
                sign_cnt_q <= SW'(SIGN_FRAMES);
                show_q     <= 1'b1;
                sign_q     <= score_sub;
            end else if (startOfFrame && (sign_cnt_q != '0)) begin
                sign_cnt_q <= sign_cnt_q - SW'(1);
                if (sign_cnt_q == SW'(1)) begin
                    show_q <= 1'b0;
                end
            end

            if (start) begin
                state_q   <= ST_RUN;
                score_q   <= '0;
                timer_q   <= START_TIME;
                frame_q   <= '0;
                win_q     <= 1'b0;
                time_up_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (win_now) begin
                            state_q <= ST_WON;
                            win_q   <= 1'b1;
                        end else begin
                            if (score_ev) begin
                                score_q <= score_d;
                            end
                            if (startOfFrame && !pause) begin
                                if (frame_q == FRAME_LAST) begin
                                    frame_q <= '0;
                                    timer_q <= timer_dec;
                                    if (timer_dec == 12'h000) begin
                                        state_q   <= ST_TIMEOUT;
                                        time_up_q <= 1'b1;
                                    end
                                end else begin
                                    frame_q <= frame_q + FW'(1);
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign numbersToShow[GOAL_BASE  +: 3] = GOAL;
    assign numbersToShow[SCORE_BASE +: 3] = score_q;
    assign numbersToShow[TIMER_BASE +: 3] = timer_q;
    assign SignToShow = sign_q;
    assign ShowSign   = show_q;
    assign WIN        = win_q;
    assign timeUp     = time_up_q;

endmodule
